// File: rtl/avalon_ibex_arbiter.sv
// avalon_ibex_arbiter: shares one Avalon-MM memory port between the Ibex
// instruction master and data master.
//
// Handshake: a command is accepted in a cycle where read or write is high and
// the matching waitrequest is low. A master holds its command stable until
// accepted. Read data returns in issue order, one beat per readdatavalid, and
// is steered back to the issuing master through a small ID FIFO.
module avalon_ibex_arbiter #(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // instruction-side slave
    input  logic [31:0] avs_instr_address,
    input  logic        avs_instr_read,
    output logic        avs_instr_waitrequest,
    output logic [31:0] avs_instr_readdata,
    output logic        avs_instr_readdatavalid,
    // data-side slave
    input  logic [31:0] avs_main_address,
    input  logic [3:0]  avs_main_byteenable,
    input  logic        avs_main_read,
    input  logic        avs_main_write,
    input  logic [31:0] avs_main_writedata,
    output logic        avs_main_waitrequest,
    output logic [31:0] avs_main_readdata,
    output logic        avs_main_readdatavalid,
    output logic [1:0]  avs_main_response,
    // shared memory master
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic [1:0]  avm_response,
    // FSM state for observation: 0 IDLE, 1 LOCK_INSTR, 2 LOCK_DATA
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutstanding);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_DATA  = 2'd2
    } state_e;

    state_e                state_q;
    logic                  last_instr_q;   // 1: instruction side won last accepted command
    logic [MaxOutstanding-1:0] id_mem_q;   // 1: entry belongs to instruction side
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       cnt_q;

    logic fifo_full;
    logic fifo_empty;
    logic data_is_rd;
    logic instr_ok;
    logic data_ok;
    logic gnt_instr;
    logic gnt_data;
    logic accept;
    logic push;
    logic pop;
    logic head_instr;

    assign fifo_full  = (cnt_q == FullCnt);
    assign fifo_empty = (cnt_q == '0);

    // Write wins when the data master asserts read and write together.
    assign data_is_rd = avs_main_read & ~avs_main_write;

    // A read may only compete when a FIFO slot is free; writes never wait on the FIFO.
    assign instr_ok = avs_instr_read & ~fifo_full;
    assign data_ok  = avs_main_write | (avs_main_read & ~fifo_full);

    // Grant selection: round-robin in IDLE, sticky to the owner while locked.
    always_comb begin
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (instr_ok && data_ok) begin
                        gnt_data  = last_instr_q;
                        gnt_instr = ~last_instr_q;
                    end else begin
                        gnt_instr = instr_ok;
                        gnt_data  = data_ok;
                    end
                end
                LOCK_INSTR: gnt_instr = instr_ok;
                LOCK_DATA:  gnt_data  = data_ok;
                default: ;
            endcase
        end
    end

    // Command mux: the granted master drives the shared port, nothing otherwise.
    always_comb begin
        avm_address    = '0;
        avm_byteenable = '0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = '0;
        if (gnt_instr) begin
            avm_address    = avs_instr_address;
            avm_byteenable = 4'hF;
            avm_read       = 1'b1;
        end else if (gnt_data) begin
            avm_address    = avs_main_address;
            avm_byteenable = avs_main_byteenable;
            avm_read       = data_is_rd;
            avm_write      = avs_main_write;
            avm_writedata  = avs_main_writedata;
        end
    end

    assign avs_instr_waitrequest = gnt_instr ? avm_waitrequest : 1'b1;
    assign avs_main_waitrequest  = gnt_data  ? avm_waitrequest : 1'b1;

    assign accept = (gnt_instr | gnt_data) & ~avm_waitrequest;
    assign push   = accept & avm_read;
    // A response with nothing outstanding (e.g. after reset) is dropped.
    assign pop    = rst_ni & avm_readdatavalid & ~fifo_empty;

    assign head_instr = id_mem_q[rd_ptr_q];

    assign avs_instr_readdatavalid = pop & head_instr;
    assign avs_main_readdatavalid  = pop & ~head_instr;
    assign avs_instr_readdata      = avm_readdata;
    assign avs_main_readdata       = avm_readdata;
    assign avs_main_response       = avm_response;

    assign dbg_state_o = state_q;

    // FSM: lock onto a stalled winner, track the last accepted requester.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_instr_q <= 1'b1;   // data side wins the first conflict
        end else begin
            if (accept) begin
                last_instr_q <= gnt_instr;
            end
            if ((gnt_instr || gnt_data) && avm_waitrequest) begin
                state_q <= gnt_instr ? LOCK_INSTR : LOCK_DATA;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    // ID FIFO pointers and occupancy; pointers wrap at MaxOutstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    // ID FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= gnt_instr;
        end
    end

endmodule

// File: tb/tb_avalon_ibex_arbiter.sv
// tb_avalon_ibex_arbiter: randomized and directed stimulus against a
// transaction-level model of the arbiter; read data checked by a scoreboard.
module tb_avalon_ibex_arbiter;

    localparam int MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni;
    initial forever #5 clk = ~clk;

    logic [31:0] avs_instr_address;
    logic        avs_instr_read;
    logic        avs_instr_waitrequest;
    logic [31:0] avs_instr_readdata;
    logic        avs_instr_readdatavalid;
    logic [31:0] avs_main_address;
    logic [3:0]  avs_main_byteenable;
    logic        avs_main_read;
    logic        avs_main_write;
    logic [31:0] avs_main_writedata;
    logic        avs_main_waitrequest;
    logic [31:0] avs_main_readdata;
    logic        avs_main_readdatavalid;
    logic [1:0]  avs_main_response;
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [1:0]  avm_response;
    logic [1:0]  dbg_state_o;

    avalon_ibex_arbiter #(.MaxOutstanding(MAX)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_ni),
        .avs_instr_address       (avs_instr_address),
        .avs_instr_read          (avs_instr_read),
        .avs_instr_waitrequest   (avs_instr_waitrequest),
        .avs_instr_readdata      (avs_instr_readdata),
        .avs_instr_readdatavalid (avs_instr_readdatavalid),
        .avs_main_address        (avs_main_address),
        .avs_main_byteenable     (avs_main_byteenable),
        .avs_main_read           (avs_main_read),
        .avs_main_write          (avs_main_write),
        .avs_main_writedata      (avs_main_writedata),
        .avs_main_waitrequest    (avs_main_waitrequest),
        .avs_main_readdata       (avs_main_readdata),
        .avs_main_readdatavalid  (avs_main_readdatavalid),
        .avs_main_response       (avs_main_response),
        .avm_address             (avm_address),
        .avm_byteenable          (avm_byteenable),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_waitrequest         (avm_waitrequest),
        .avm_readdata            (avm_readdata),
        .avm_readdatavalid       (avm_readdatavalid),
        .avm_response            (avm_response),
        .dbg_state_o             (dbg_state_o)
    );

    // ---------------- stimulus / model state ----------------
    typedef struct packed { logic drop; logic [31:0] addr; } icmd_t;
    typedef struct packed { logic rd; logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } dcmd_t;

    icmd_t icmd_q[$];
    dcmd_t dcmd_q[$];
    icmd_t i_cur;
    dcmd_t d_cur;
    logic  i_act, d_act;
    int    i_age;

    logic [33:0] mem_q[$];      // memory slave: responses owed {resp, data}
    logic [33:0] exp_i_q[$];    // scoreboard: expected instr read beats
    logic [33:0] exp_d_q[$];    // scoreboard: expected data read beats {resp, data}
    logic        ord_q[$];      // model: outstanding reads in issue order, 1 = instr
    int          lock_own;      // model: 0 none, 1 instr, 2 data
    int          last_own;      // model: 1 instr, 2 data

    logic wait_sched_q[$];
    logic rsp_sched_q[$];
    int   wait_pct, rsp_pct, spur_pct, load_pct;
    logic rst_cmd;

    int n_checks = 0;
    int n_fail   = 0;

    // memory contents and response code are a fixed function of the address
    function automatic logic [33:0] mem_val(input logic [31:0] a);
        return {a[5:4], a ^ 32'h3C5A_96E1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver + model, one clock per call ----------------
    task automatic cycle();
        logic full, ie, de, drd, dwr, e_rd, e_wr, acc, rsp_go;
        logic [33:0] v;
        int winner;
        @(negedge clk);
        rst_ni = rst_cmd;
        if (i_act && i_cur.drop && i_age >= 1) i_act = 1'b0;
        if (!i_act && icmd_q.size() > 0 && $urandom_range(99) < load_pct) begin
            i_cur = icmd_q.pop_front(); i_act = 1'b1; i_age = 0;
        end
        if (!d_act && dcmd_q.size() > 0 && $urandom_range(99) < load_pct) begin
            d_cur = dcmd_q.pop_front(); d_act = 1'b1;
        end
        avs_instr_read      = i_act;
        avs_instr_address   = i_cur.addr;
        avs_main_read       = d_act && d_cur.rd;
        avs_main_write      = d_act && d_cur.wr;
        avs_main_address    = d_cur.addr;
        avs_main_byteenable = d_cur.be;
        avs_main_writedata  = d_cur.wdata;
        // memory slave
        if (wait_sched_q.size() > 0) avm_waitrequest = wait_sched_q.pop_front();
        else avm_waitrequest = ($urandom_range(99) < wait_pct);
        if (rsp_sched_q.size() > 0) rsp_go = rsp_sched_q.pop_front();
        else rsp_go = ($urandom_range(99) < rsp_pct);
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom();
        avm_response      = 2'($urandom_range(3));
        if (rsp_go && mem_q.size() > 0) begin
            v = mem_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = v[31:0];
            avm_response      = v[33:32];
        end else if (mem_q.size() == 0 && $urandom_range(99) < spur_pct) begin
            avm_readdatavalid = 1'b1;
        end
        #1;
        chk("instr_rdata_pass", 64'(avs_instr_readdata), 64'(avm_readdata));
        chk("main_rdata_pass", 64'(avs_main_readdata), 64'(avm_readdata));
        if (!rst_ni) begin
            chk("rst_avm_read", 64'(avm_read), 64'd0);
            chk("rst_avm_write", 64'(avm_write), 64'd0);
            chk("rst_instr_wait", 64'(avs_instr_waitrequest), 64'd1);
            chk("rst_main_wait", 64'(avs_main_waitrequest), 64'd1);
            chk("rst_instr_rdv", 64'(avs_instr_readdatavalid), 64'd0);
            chk("rst_main_rdv", 64'(avs_main_readdatavalid), 64'd0);
            lock_own = 0;
            last_own = 1;
            ord_q.delete();
            exp_i_q.delete();
            exp_d_q.delete();
        end else begin
            chk("dbg_state", 64'(dbg_state_o), 64'(lock_own));
            drd  = d_act && d_cur.rd;
            dwr  = d_act && d_cur.wr;
            full = (ord_q.size() >= MAX);
            ie   = i_act && !full;
            de   = dwr || (drd && !full);
            winner = 0;
            if (lock_own == 1) winner = ie ? 1 : 0;
            else if (lock_own == 2) winner = de ? 2 : 0;
            else if (ie && de) winner = (last_own == 1) ? 2 : 1;
            else if (ie) winner = 1;
            else if (de) winner = 2;
            e_rd = (winner == 1) || (winner == 2 && !dwr);
            e_wr = (winner == 2) && dwr;
            chk("avm_read", 64'(avm_read), 64'(e_rd));
            chk("avm_write", 64'(avm_write), 64'(e_wr));
            chk("instr_wait", 64'(avs_instr_waitrequest), 64'(!(winner == 1 && !avm_waitrequest)));
            chk("main_wait", 64'(avs_main_waitrequest), 64'(!(winner == 2 && !avm_waitrequest)));
            if (winner == 1) begin
                chk("instr_addr", 64'(avm_address), 64'(i_cur.addr));
                chk("instr_be", 64'(avm_byteenable), 64'hF);
            end else if (winner == 2) begin
                chk("data_addr", 64'(avm_address), 64'(d_cur.addr));
                chk("data_be", 64'(avm_byteenable), 64'(d_cur.be));
                if (dwr) chk("data_wdata", 64'(avm_writedata), 64'(d_cur.wdata));
            end
            if (avm_readdatavalid && ord_q.size() > 0) begin
                chk("route_instr_rdv", 64'(avs_instr_readdatavalid), 64'(ord_q[0]));
                chk("route_main_rdv", 64'(avs_main_readdatavalid), 64'(!ord_q[0]));
                void'(ord_q.pop_front());
            end else begin
                chk("idle_instr_rdv", 64'(avs_instr_readdatavalid), 64'd0);
                chk("idle_main_rdv", 64'(avs_main_readdatavalid), 64'd0);
            end
            acc = (winner != 0) && !avm_waitrequest;
            if (acc) begin
                last_own = winner;
                lock_own = 0;
                if (winner == 1) begin
                    ord_q.push_back(1'b1);
                    exp_i_q.push_back(mem_val(i_cur.addr));
                    i_act = 1'b0;
                end else begin
                    if (!dwr) begin
                        ord_q.push_back(1'b0);
                        exp_d_q.push_back(mem_val(d_cur.addr));
                    end
                    d_act = 1'b0;
                end
            end else begin
                lock_own = winner;
            end
            if (i_act) i_age++;
        end
        if (avm_read && !avm_waitrequest) mem_q.push_back(mem_val(avm_address));
    endtask

    task automatic do_reset(input int n);
        rst_cmd = 1'b0;
        i_act = 1'b0;
        d_act = 1'b0;
        icmd_q.delete();
        dcmd_q.delete();
        wait_sched_q.delete();
        rsp_sched_q.delete();
        repeat (n) cycle();
        rst_cmd = 1'b1;
    endtask

    // let every command finish and every response return, within a cycle budget
    task automatic drain();
        int n;
        n = 0;
        wait_pct = 0; rsp_pct = 100; spur_pct = 0; load_pct = 100;
        while ((i_act || d_act || icmd_q.size() > 0 || dcmd_q.size() > 0 ||
                mem_q.size() > 0 || ord_q.size() > 0) && n < 200) begin
            cycle();
            n++;
        end
        repeat (2) cycle();
        chk("drain_in_budget", 64'(n < 200), 64'd1);
        chk("instr_beats_left", 64'(exp_i_q.size()), 64'd0);
        chk("data_beats_left", 64'(exp_d_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [33:0] e;
        #2;
        if (avs_instr_readdatavalid) begin
            if (exp_i_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL instr_rdv_unexpected: readdatavalid=1, expected 0 (t=%0t)", $time);
            end else begin
                e = exp_i_q.pop_front();
                chk("instr_rdata", 64'(avs_instr_readdata), 64'(e[31:0]));
            end
        end
        if (avs_main_readdatavalid) begin
            if (exp_d_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL main_rdv_unexpected: readdatavalid=1, expected 0 (t=%0t)", $time);
            end else begin
                e = exp_d_q.pop_front();
                chk("main_rdata", 64'(avs_main_readdata), 64'(e[31:0]));
                chk("main_resp", 64'(avs_main_response), 64'(e[33:32]));
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        dcmd_t dc;
        int r;
        rst_ni = 1'b0; rst_cmd = 1'b0;
        avs_instr_address = '0; avs_instr_read = 1'b0;
        avs_main_address = '0; avs_main_byteenable = '0; avs_main_read = 1'b0;
        avs_main_write = 1'b0; avs_main_writedata = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; avm_response = '0;
        i_cur = '0; d_cur = '0; i_act = 1'b0; d_act = 1'b0; i_age = 0;
        lock_own = 0; last_own = 1;
        wait_pct = 0; rsp_pct = 0; spur_pct = 0; load_pct = 100;
        do_reset(3);

        // simultaneous reads right after reset: data first, then instr
        icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_1000});
        dcmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_2010, be: 4'h3, wdata: 32'h0});
        repeat (3) cycle();
        drain();

        // instr read stalled three cycles while a data write waits behind it
        wait_sched_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_3010});
        cycle();
        dcmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0000_3100, be: 4'h6, wdata: 32'hCAFE_F00D});
        repeat (5) cycle();
        drain();

        // locked instr master withdraws its request: nothing forwarded that cycle
        wait_sched_q = '{1'b1, 1'b1};
        icmd_q.push_back('{drop: 1'b1, addr: 32'h0000_3300});
        cycle();
        dcmd_q.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'h0000_3400, be: 4'hF, wdata: 32'h1234_5678});
        repeat (4) cycle();
        drain();

        // fill the ID FIFO with instr reads; one response frees the fifth
        rsp_pct = 0;
        repeat (5) icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_5000 + 32'($urandom_range(255)) * 4});
        repeat (6) cycle();
        rsp_sched_q.push_back(1'b1);
        repeat (3) cycle();
        drain();

        // interleaved reads, data's first read answered with response 2'b10
        rsp_pct = 0;
        icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_4000});
        dcmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_4020, be: 4'hF, wdata: 32'h0});
        dcmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_4040, be: 4'hF, wdata: 32'h0});
        icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_4080});
        repeat (6) cycle();
        drain();

        // read and write together: only the write goes out
        dcmd_q.push_back('{rd: 1'b1, wr: 1'b1, addr: 32'h0000_6000, be: 4'hA, wdata: 32'hDEAD_BEEF});
        dcmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_6030, be: 4'hF, wdata: 32'h0});
        repeat (4) cycle();
        drain();

        // reset with three reads outstanding; late responses must be dropped
        rsp_pct = 0;
        icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_7000});
        dcmd_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_7010, be: 4'hF, wdata: 32'h0});
        icmd_q.push_back('{drop: 1'b0, addr: 32'h0000_7020});
        repeat (5) cycle();
        do_reset(2);
        rsp_pct = 100;
        repeat (6) cycle();
        drain();

        // randomized traffic
        wait_pct = 30; rsp_pct = 35; spur_pct = 5; load_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (icmd_q.size() < 2) icmd_q.push_back('{drop: 1'b0, addr: $urandom()});
            if (dcmd_q.size() < 2) begin
                r = $urandom_range(9);
                dc.rd    = (r < 5) || (r == 9);
                dc.wr    = (r >= 5);
                dc.addr  = $urandom();
                dc.be    = 4'($urandom_range(15));
                dc.wdata = $urandom();
                dcmd_q.push_back(dc);
            end
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_ibex_arbiter.md
AVALON_IBEX_ARBITER -- requirements
Module: avalon_ibex_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 4, meaning max accepted-but-unanswered reads (legal 1..8).
REQ-002 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port avs_instr_address  in  32  instruction-side word address.
REQ-005 SHALL have port avs_instr_read  in  1  instruction read request.
REQ-006 SHALL have port avs_instr_waitrequest  out  1  instruction command stall.
REQ-007 SHALL have port avs_instr_readdata  out  32  instruction read data.
REQ-008 SHALL have port avs_instr_readdatavalid  out  1  instruction read data valid.
REQ-009 SHALL have port avs_main_address  in  32  data-side word address.
REQ-010 SHALL have port avs_main_byteenable  in  4  data-side byte enables.
REQ-011 SHALL have port avs_main_read  in  1  data read request.
REQ-012 SHALL have port avs_main_write  in  1  data write request.
REQ-013 SHALL have port avs_main_writedata  in  32  data write data.
REQ-014 SHALL have port avs_main_waitrequest  out  1  data command stall.
REQ-015 SHALL have port avs_main_readdata  out  32  data read data.
REQ-016 SHALL have port avs_main_readdatavalid  out  1  data read data valid.
REQ-017 SHALL have port avs_main_response  out  2  data read response code.
REQ-018 SHALL have ports avm_address (out 32), avm_byteenable (out 4), avm_read (out 1), avm_write (out 1), avm_writedata (out 32): shared memory command.
REQ-019 SHALL have ports avm_waitrequest (in 1), avm_readdata (in 32), avm_readdatavalid (in 1), avm_response (in 2): shared memory response.

Function
REQ-020 SHALL run an FSM with states IDLE, LOCK_INSTR and LOCK_DATA.
REQ-021 IDLE: grant is combinational, so a command reaches avm_* in the same cycle as the request; zero added command latency.
REQ-022 Conflict in IDLE: round-robin on a 1-bit last-granted pointer; the pointer flips to the winner on each accepted command.
REQ-023 Granted command stalled (avm_waitrequest=1): go to LOCK_<winner>; the grant holds and avm_* stays sourced from the winner until accepted, then return to IDLE.
REQ-024 Locked requester drops its request before acceptance (protocol violation): return to IDLE next cycle with no command forwarded.
REQ-025 Non-granted requester SHALL see waitrequest=1; granted requester SHALL see avm_waitrequest.
REQ-026 avm_read/avm_write SHALL be 0 when no requester is granted.
REQ-027 Instruction commands SHALL drive avm_byteenable=4'hF and avm_write=0.
REQ-028 avs_main_read and avs_main_write asserted together: write wins and the read is ignored.
REQ-029 Accepted read (command asserted, avm_waitrequest=0) SHALL push the requester ID into a MaxOutstanding-deep FIFO.
REQ-030 Writes SHALL push nothing.
REQ-031 Each avm_readdatavalid SHALL pop one ID and route readdata, readdatavalid and response combinationally to that requester in the same cycle; the other requester's readdatavalid SHALL be 0.
REQ-032 FIFO full: any read from either requester SHALL see waitrequest=1 and no avm_read SHALL be issued, even if a pop occurs that cycle.
REQ-033 Writes SHALL proceed while the FIFO is full.
REQ-034 Simultaneous push and pop when not full: count unchanged, order preserved; FIFO pointers wrap modulo MaxOutstanding.
REQ-035 avm_readdatavalid with an empty FIFO SHALL be dropped and not forwarded to either requester.
REQ-036 avs_instr_readdata and avs_main_readdata SHALL equal avm_readdata unconditionally; only valid is gated.

Reset
REQ-037 When rst_ni=0 at a clock edge: FSM=IDLE, FIFO empty, pointer selects data first.
REQ-038 While rst_ni=0: avm_read=avm_write=0, both avs waitrequest=1, both readdatavalid=0.
REQ-039 Reset mid-transaction SHALL discard outstanding IDs; responses arriving after reset follow REQ-035.

Verification
REQ-040 Both read same cycle after reset, avm_waitrequest=0: data read issued cycle 0, instr cycle 1; return order D,I routed correctly.
REQ-041 Instr read granted, avm_waitrequest=1 for 3 cycles while data writes: avm_address holds instr address 4 cycles, data waitrequest=1 throughout, data write issued cycle 4.
REQ-042 MaxOutstanding=4, 5 back-to-back instr reads, no responses: 4 accepted, 5th waitrequest=1; one readdatavalid frees the slot and the 5th issues the next cycle.
REQ-043 Interleaved reads I,D,D,I then responses with avm_response 2'b00,2'b10,2'b00,2'b00: data sees 2'b10 on its first read only.
REQ-044 Assert rst_ni=0 with 3 reads outstanding, release, inject avm_readdatavalid: no readdatavalid on either requester.
REQ-045 Data read+write asserted together: single avm_write=1, avm_read=0, FIFO count unchanged.
